// File: rtl/event_pkg.sv
// Shared types and widths for the event burst generator and its bench.
package event_pkg;

    localparam int unsigned CW = 6;
    localparam int unsigned NW = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter with zero flag; it holds at zero rather than wrapping.
module down_counter #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero_c
);

    assign zero_c = (cnt == '0);

    // Load has priority over decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !zero_c) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/event_burst_gen.sv
// Generates num_bursts bursts of burst_len evnt cycles separated by gap_len idle cycles.
module event_burst_gen
    import event_pkg::*;
#(
    parameter int unsigned CW = event_pkg::CW,
    parameter int unsigned NW = event_pkg::NW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] burst_len,
    input  logic [CW-1:0] gap_len,
    input  logic [NW-1:0] num_bursts,
    output logic          evnt,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] burst_idx
);

    state_e        state_q;
    state_e        state_d;

    logic [CW-1:0] blen_q;
    logic [CW-1:0] glen_q;
    logic [NW-1:0] nb_q;

    logic          capture;
    logic          idx_inc;
    logic          cnt_load;
    logic [CW-1:0] cnt_val;
    logic          cnt_dec;
    logic [CW-1:0] cnt_q;
    logic          cnt_zero;
    logic          phase_end;
    logic          last_burst;
    logic [CW-1:0] gap_eff;

    logic          evnt_d;
    logic          busy_d;
    logic          done_d;

    // One counter times both BURST and GAP; it is reloaded at every phase change.
    down_counter #(
        .W(CW)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .load_val(cnt_val),
        .dec     (cnt_dec),
        .cnt     (cnt_q),
        .zero_c  (cnt_zero)
    );

    assign phase_end  = cnt_zero || (cnt_q == CW'(1));
    assign last_burst = (burst_idx == (nb_q - NW'(1)));
    // A zero gap still separates bursts by one cycle.
    assign gap_eff    = (glen_q == '0) ? CW'(1) : glen_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        idx_inc  = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    capture = 1'b1;
                    if ((burst_len == '0) || (num_bursts == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_BURST;
                        cnt_load = 1'b1;
                        cnt_val  = burst_len;
                    end
                end
            end
            ST_BURST: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (phase_end) begin
                    if (last_burst) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_GAP;
                        cnt_load = 1'b1;
                        cnt_val  = gap_eff;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (phase_end) begin
                    state_d  = ST_BURST;
                    cnt_load = 1'b1;
                    cnt_val  = blen_q;
                    idx_inc  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state; registered below so outputs track state_q.
    always_comb begin
        evnt_d = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            ST_BURST: begin
                evnt_d = 1'b1;
                busy_d = 1'b1;
            end
            ST_GAP: begin
                busy_d = 1'b1;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                evnt_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evnt <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            evnt <= evnt_d;
            busy <= busy_d;
            done <= done_d;
        end
    end

    // Sequence parameters are frozen at an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            blen_q    <= '0;
            glen_q    <= '0;
            nb_q      <= '0;
            burst_idx <= '0;
        end else if (capture) begin
            blen_q    <= burst_len;
            glen_q    <= gap_len;
            nb_q      <= num_bursts;
            burst_idx <= '0;
        end else if (idx_inc) begin
            burst_idx <= burst_idx + NW'(1);
        end
    end

endmodule

// File: tb/tb_event_burst_gen.sv
// Directed self-checking bench for event_burst_gen with a behavioural run-length monitor.
module tb_event_burst_gen;
    import event_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [CW-1:0] burst_len;
    logic [CW-1:0] gap_len;
    logic [NW-1:0] num_bursts;
    logic          evnt;
    logic          busy;
    logic          done;
    logic [NW-1:0] burst_idx;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    event_burst_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .burst_len (burst_len),
        .gap_len   (gap_len),
        .num_bursts(num_bursts),
        .evnt      (evnt),
        .busy      (busy),
        .done      (done),
        .burst_idx (burst_idx)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a start for one sampled edge; returns #1 after that edge.
    task automatic do_start(input int bl, input int gl, input int nb);
        burst_len  = CW'(bl);
        gap_len    = CW'(gl);
        num_bursts = NW'(nb);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        burst_len = CW'(4); gap_len = CW'(1); num_bursts = NW'(2);
        tick();
        tick();
        tests++; if (evnt !== 1'b0) begin fails++; $display("FAIL reset_evnt got %b want 0", evnt); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (burst_idx !== '0) begin fails++; $display("FAIL reset_idx got %0d want 0", burst_idx); end
        start = 1'b0; abort = 1'b0;
        rst = 1'b0;
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_release_busy got %b want 0", busy); end
    endtask

    task automatic test_basic;
        logic exp_ev  [8] = '{1, 1, 1, 0, 0, 1, 1, 1};
        int   exp_idx [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
        do_start(3, 2, 2);
        for (int i = 0; i < 8; i++) begin
            tests++; if (evnt !== exp_ev[i]) begin fails++; $display("FAIL basic_evnt[%0d] got %b want %b", i, evnt, exp_ev[i]); end
            tests++; if (burst_idx !== NW'(exp_idx[i])) begin fails++; $display("FAIL basic_idx[%0d] got %0d want %0d", i, burst_idx, exp_idx[i]); end
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy[%0d] got %b want 1", i, busy); end
            // Start and new parameters mid-sequence must not disturb the run.
            if (i == 2) begin
                start = 1'b1; burst_len = CW'(7); gap_len = CW'(9); num_bursts = NW'(5);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL basic_done got %b want 1", done); end
        tests++; if (busy !== 1'b0 || evnt !== 1'b0) begin fails++; $display("FAIL basic_done_quiet busy=%b evnt=%b want 0 0", busy, evnt); end
        tick();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_width got %b want 0", done); end
        tests++; if (burst_idx !== NW'(1)) begin fails++; $display("FAIL basic_idx_hold got %0d want 1", burst_idx); end
    endtask

    // Run-length monitor with thresh=3: alarm rises when a run exceeds 3 evnt cycles.
    task automatic test_monitor;
        int   run;
        int   nev;
        int   rise_at;
        logic alarm;
        do_start(5, 0, 1);
        run = 0; nev = 0; rise_at = 0; alarm = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (evnt === 1'b1) begin nev++; run++; end else run = 0;
            if (!alarm && run > 3) begin alarm = 1'b1; rise_at = nev; end
            tick();
        end
        tests++; if (rise_at != 4) begin fails++; $display("FAIL mon_rise_at got %0d want 4", rise_at); end
        tests++; if (nev != 5) begin fails++; $display("FAIL mon_count5 got %0d want 5", nev); end

        do_start(3, 1, 3);
        run = 0; nev = 0; alarm = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (evnt === 1'b1) begin nev++; run++; end else run = 0;
            if (run > 3) alarm = 1'b1;
            tick();
        end
        tests++; if (alarm !== 1'b0) begin fails++; $display("FAIL mon_no_alarm got %b want 0", alarm); end
        tests++; if (nev != 9) begin fails++; $display("FAIL mon_count9 got %0d want 9", nev); end
    endtask

    task automatic test_gap_zero;
        logic exp_ev [5] = '{1, 1, 0, 1, 1};
        do_start(2, 0, 2);
        for (int i = 0; i < 5; i++) begin
            tests++; if (evnt !== exp_ev[i]) begin fails++; $display("FAIL gap0_evnt[%0d] got %b want %b", i, evnt, exp_ev[i]); end
            tick();
        end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL gap0_done got %b want 1", done); end
        tick();
    endtask

    task automatic test_zero_len;
        do_start(0, 4, 3);
        tests++; if (evnt !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL zlen_quiet evnt=%b busy=%b want 0 0", evnt, busy); end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL zlen_done got %b want 1", done); end
        tick();
        tests++; if (done !== 1'b0 || evnt !== 1'b0) begin fails++; $display("FAIL zlen_after done=%b evnt=%b want 0 0", done, evnt); end
        do_start(5, 4, 0);
        tests++; if (evnt !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL znb_quiet evnt=%b busy=%b want 0 0", evnt, busy); end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL znb_done got %b want 1", done); end
        tick();
    endtask

    task automatic test_abort;
        int done_seen;
        do_start(10, 2, 1);
        tick();
        tests++; if (evnt !== 1'b1) begin fails++; $display("FAIL abort_pre_evnt got %b want 1", evnt); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests++; if (evnt !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL abort_stop evnt=%b busy=%b want 0 0", evnt, busy); end
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (done === 1'b1 || evnt === 1'b1) done_seen++;
            tick();
        end
        tests++; if (done_seen != 0) begin fails++; $display("FAIL abort_no_done got %0d active cycles want 0", done_seen); end
        do_start(1, 0, 1);
        tests++; if (evnt !== 1'b1) begin fails++; $display("FAIL abort_restart got %b want 1", evnt); end
        tick();
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL abort_restart_done got %b want 1", done); end
        tick();
    endtask

    task automatic test_abort_start_idle;
        burst_len = CW'(3); gap_len = CW'(1); num_bursts = NW'(1);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tests++; if (busy !== 1'b0 || evnt !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL abort_wins busy=%b evnt=%b done=%b want 0 0 0", busy, evnt, done); end
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_wins_hold got %b want 0", busy); end
    endtask

    task automatic test_max_len;
        int cnt;
        int seen;
        do_start(63, 0, 1);
        cnt = 0; seen = 0;
        for (int c = 0; c < 100; c++) begin
            if (evnt === 1'b1) cnt++;
            if (done === 1'b1) begin seen = 1; break; end
            tick();
        end
        tests++; if (cnt != 63) begin fails++; $display("FAIL max_len_count got %0d want 63", cnt); end
        tests++; if (seen != 1) begin fails++; $display("FAIL max_len_done got %0d want 1", seen); end
        tick();
    endtask

    task automatic test_rst_gap;
        do_start(2, 5, 2);
        tick();
        tick();
        tests++; if (busy !== 1'b1 || evnt !== 1'b0) begin fails++; $display("FAIL rstgap_in_gap busy=%b evnt=%b want 1 0", busy, evnt); end
        start = 1'b1; rst = 1'b1;
        tick();
        tests++; if (evnt !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || burst_idx !== '0) begin
            fails++; $display("FAIL rstgap_clear evnt=%b busy=%b done=%b idx=%0d want 0 0 0 0", evnt, busy, done, burst_idx);
        end
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstgap_hold got %b want 0", busy); end
        rst = 1'b0;
        tick();
        start = 1'b0;
        tests++; if (evnt !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL rstgap_restart evnt=%b busy=%b want 1 1", evnt, busy); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout after %0d tests", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_monitor();
        test_gap_zero();
        test_zero_len();
        test_abort();
        test_abort_start_idle();
        test_max_len();
        test_rst_gap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
